// File: rtl/lb_count_ctrl.sv
// lb_count_ctrl: sequencer for a cascade of 4-bit loadable up/down counter
// slices. It drives the chain's enable, load select, direction and carry-in,
// supplies the load data, and watches the chain's final carry-out for
// terminal count. The result is a one-shot or periodic interval timer.
//
// Optional build macro: LB_COUNT_CTRL_PRESCALE_EN
//   Adds parameter PRE_W and input PRESCALE. The chain then advances once
//   every PRESCALE+1 cycles while running.
//
// state | meaning
// IDLE  | chain disabled, waiting for START
// LOAD  | one cycle, chain loads the latched value
// RUN   | chain counts; reloads (periodic) or stops (one-shot) at terminal
// HALT  | one-shot finished, count held at terminal value, DONE high
module lb_count_ctrl #(
    parameter int SLICES = 4,
`ifdef LB_COUNT_CTRL_PRESCALE_EN
    parameter int PRE_W  = 8,
`endif
    localparam int W     = 4 * SLICES
) (
    input  logic         CK,
    input  logic         CD,
    input  logic         START,
    input  logic         STOP,
    input  logic         MODE,
    input  logic         DIR,
    input  logic [W-1:0] LOADVAL,
`ifdef LB_COUNT_CTRL_PRESCALE_EN
    input  logic [PRE_W-1:0] PRESCALE,
`endif
    input  logic         CO_IN,
    output logic         SP,
    output logic         SD,
    output logic         CON,
    output logic         CI,
    output logic [W-1:0] D,
    output logic         BUSY,
    output logic         DONE,
    output logic         TC
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t       state_q;
    logic         mode_q;
    logic         dir_q;
    logic [W-1:0] val_q;
    logic         tc_q;
    logic         tc;
    logic         tick;

    // Terminal count as seen by this direction: all ones up, zero down
    // (the chain's carry-out is active-low at zero when counting down).
    assign tc = dir_q ? ~CO_IN : CO_IN;

`ifdef LB_COUNT_CTRL_PRESCALE_EN
    logic [PRE_W-1:0] pre_val_q;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    assign tick = (pre_q == '0);

    // Prescale down-counter: reload at LOAD and on every tick, else count.
    always_comb begin
        pre_d = pre_q;
        if (state_q == S_LOAD) begin
            pre_d = pre_val_q;
        end else if (state_q == S_RUN) begin
            pre_d = tick ? pre_val_q : pre_q - 1'b1;
        end
    end

    // Prescale registers; the reload value is captured with the other START inputs.
    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            pre_val_q <= '0;
            pre_q     <= '0;
        end else begin
            pre_q <= pre_d;
            if ((state_q == S_IDLE && START && !STOP) ||
                (state_q == S_HALT && START && !STOP)) begin
                pre_val_q <= PRESCALE;
            end
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Main sequencer: state, latched configuration and the registered TC pulse.
    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            val_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START && !STOP) begin
                        mode_q  <= MODE;
                        dir_q   <= DIR;
                        val_q   <= LOADVAL;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_q <= STOP ? S_IDLE : S_RUN;
                end
                S_RUN: begin
                    if (STOP) begin
                        state_q <= S_IDLE;
                    end else if (tick && tc) begin
                        tc_q <= 1'b1;
                        if (!mode_q) begin
                            state_q <= S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    if (STOP) begin
                        state_q <= S_IDLE;
                    end else if (START) begin
                        mode_q  <= MODE;
                        dir_q   <= DIR;
                        val_q   <= LOADVAL;
                        state_q <= S_LOAD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Chain enable/load select. These must react in the same cycle to STOP
    // and to terminal count, so they are decoded combinationally.
    always_comb begin
        SP = 1'b0;
        SD = 1'b0;
        case (state_q)
            S_LOAD: begin
                SP = !STOP;
                SD = !STOP;
            end
            S_RUN: begin
                if (STOP) begin
                    SP = 1'b0;
                    SD = 1'b0;
                end else if (tick && tc) begin
                    // Periodic reloads instead of wrapping; one-shot freezes.
                    SP = mode_q;
                    SD = mode_q;
                end else begin
                    SP = tick;
                    SD = 1'b0;
                end
            end
            default: begin
                SP = 1'b0;
                SD = 1'b0;
            end
        endcase
    end

    assign CON  = ~dir_q;
    assign CI   = ~dir_q;
    assign D    = val_q;
    assign BUSY = (state_q == S_LOAD) || (state_q == S_RUN);
    assign DONE = (state_q == S_HALT);
    assign TC   = tc_q;

endmodule
